// File: rtl/uart_frame_decoder_if.sv
// Byte-wide AXI-Stream link used on both sides of the UART frame decoder.
// tlast/tuser are only meaningful on the decoder output.
interface uart_frame_decoder_if;
    logic [7:0] tdata;
    logic       tkeep;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/uart_frame_decoder.sv
// Frame decoder for the UART rx byte stream: SOF, LEN, payload, CSUM.
// Emits each payload as one AXIS packet and counts good and bad frames.
module uart_frame_decoder #(
    parameter logic [7:0]  SOF_BYTE       = 8'h7E,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 aclk,
    input  logic                 areset_n,
    uart_frame_decoder_if.slave  s_axis,
    uart_frame_decoder_if.master m_axis,
    output logic [CNT_WIDTH-1:0] frame_ok_cnt,
    output logic [CNT_WIDTH-1:0] frame_err_cnt
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StHunt, StLen, StPay, StCsum} state_e;

    state_e                state_q, state_d;
    logic [7:0]            len_q, len_d, cnt_q, cnt_d, sum_q, sum_d, pend_q, pend_d;
    logic                  bad_q, bad_d, pend_valid_q, pend_valid_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [7:0]            m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d, m_tuser_q, m_tuser_d;
    logic [CNT_WIDTH-1:0]  ok_q, ok_d, err_q, err_d;
    logic                  out_free, accept, timeout, bad_final;

    assign out_free = !m_tvalid_q || m_axis.tready;
    assign accept   = s_axis.tvalid && out_free;
    // An accepted byte always wins over a coincident timeout.
    assign timeout  = (state_q != StHunt) && (timer_q == TimeoutVal) && !accept && out_free;
    assign bad_final = bad_q || ((sum_q + s_axis.tdata) != 8'd0) || !s_axis.tkeep;

    assign s_axis.tready = out_free;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign m_axis.tuser  = m_tuser_q;
    assign m_axis.tkeep  = 1'b1;
    assign frame_ok_cnt  = ok_q;
    assign frame_err_cnt = err_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        bad_d        = bad_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q && !m_axis.tready;
        m_tlast_d    = m_tlast_q;
        m_tuser_d    = m_tuser_q;
        ok_d         = ok_q;
        err_d        = err_q;

        if (state_q == StHunt || accept) begin
            timer_d = '0;
        end else if (timer_q != TimeoutVal) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        unique case (state_q)
            StHunt: begin
                if (accept && s_axis.tkeep && s_axis.tdata == SOF_BYTE) state_d = StLen;
            end
            StLen: begin
                if (accept) begin
                    len_d        = s_axis.tdata;
                    cnt_d        = 8'd0;
                    sum_d        = s_axis.tdata;
                    bad_d        = !s_axis.tkeep;
                    pend_valid_d = 1'b0;
                    state_d      = (s_axis.tdata == 8'd0) ? StCsum : StPay;
                end
            end
            StPay: begin
                if (accept) begin
                    sum_d = sum_q + s_axis.tdata;
                    bad_d = bad_q || !s_axis.tkeep;
                    if (pend_valid_q) begin
                        m_tdata_d  = pend_q;
                        m_tvalid_d = 1'b1;
                        m_tlast_d  = 1'b0;
                        m_tuser_d  = 1'b0;
                    end
                    pend_d       = s_axis.tdata;
                    pend_valid_d = 1'b1;
                    cnt_d        = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) state_d = StCsum;
                end
            end
            StCsum: begin
                if (accept) begin
                    if (len_q != 8'd0) begin
                        m_tdata_d  = pend_q;
                        m_tvalid_d = 1'b1;
                        m_tlast_d  = 1'b1;
                        m_tuser_d  = bad_final;
                    end
                    pend_valid_d = 1'b0;
                    if (bad_final) begin
                        if (err_q != '1) err_d = err_q + 1'b1;
                    end else if (ok_q != '1) begin
                        ok_d = ok_q + 1'b1;
                    end
                    state_d = StHunt;
                end
            end
            default: state_d = StHunt;
        endcase

        // Abort a stalled frame: flush the held byte as a bad last beat.
        if (timeout) begin
            if (pend_valid_q) begin
                m_tdata_d  = pend_q;
                m_tvalid_d = 1'b1;
                m_tlast_d  = 1'b1;
                m_tuser_d  = 1'b1;
            end
            pend_valid_d = 1'b0;
            if (err_q != '1) err_d = err_q + 1'b1;
            state_d = StHunt;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= StHunt;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
            sum_q        <= 8'd0;
            bad_q        <= 1'b0;
            pend_q       <= 8'd0;
            pend_valid_q <= 1'b0;
            timer_q      <= '0;
            m_tdata_q    <= 8'd0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tuser_q    <= 1'b0;
            ok_q         <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            bad_q        <= bad_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            timer_q      <= timer_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            m_tuser_q    <= m_tuser_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder; output beats are logged as {tuser, tlast, tdata}.
// Checksums are chosen so that LEN + payload + CSUM == 0 mod 256.
module tb_uart_frame_decoder;
    localparam int unsigned TO = 40;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CW-1:0] ok_cnt, err_cnt;
    always #5 clk = ~clk;

    uart_frame_decoder_if s_if ();
    uart_frame_decoder_if m_if ();

    uart_frame_decoder #(
        .SOF_BYTE      (8'h7E),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .aclk         (clk),
        .areset_n     (rst_n),
        .s_axis       (s_if.slave),
        .m_axis       (m_if.master),
        .frame_ok_cnt (ok_cnt),
        .frame_err_cnt(err_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_if.tvalid && m_if.tready) got_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic k);
        bit done = 1'b0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_if.tready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        check_eq("send_accept", 32'(done), 32'd1);
    endtask

    task automatic send_frame1();
        send(8'h7E, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
        send(8'h97, 1);
    endtask

    task automatic expect_frame1();
        exp_q.push_back(10'h011); exp_q.push_back(10'h022); exp_q.push_back(10'h133);
    endtask

    task automatic expect_out(input string tag);
        idle(5);
        check_eq({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check_eq({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit saw_valid, rdy_low, stable;
        logic [9:0] snap;
        s_if.tdata  = 8'h00;
        s_if.tkeep  = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b1;
        do_reset();

        check_eq("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check_eq("rst_m_bits", 32'({m_if.tuser, m_if.tlast, m_if.tdata}), 32'd0);
        check_eq("rst_counters", 32'({ok_cnt, err_cnt}), 32'd0);
        check_eq("rst_s_tready", 32'(s_if.tready), 32'd1);

        // Good frame.
        send_frame1();
        expect_frame1();
        expect_out("t1");
        check_eq("t1_ok", 32'(ok_cnt), 32'd1);
        check_eq("t1_err", 32'(err_cnt), 32'd0);

        // Bad checksum.
        do_reset();
        send(8'h7E, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
        send(8'hB8, 1);
        exp_q.push_back(10'h011); exp_q.push_back(10'h022); exp_q.push_back(10'h333);
        expect_out("t2");
        check_eq("t2_ok", 32'(ok_cnt), 32'd0);
        check_eq("t2_err", 32'(err_cnt), 32'd1);

        // Garbage and a dirty SOF before the frame; payload byte with tkeep=0.
        do_reset();
        send(8'h00, 1); send(8'h7E, 0);
        send(8'h7E, 1); send(8'h02, 1); send(8'hAA, 0); send(8'h55, 1); send(8'hFF, 1);
        exp_q.push_back(10'h0AA); exp_q.push_back(10'h355);
        expect_out("t3");
        check_eq("t3_ok", 32'(ok_cnt), 32'd0);
        check_eq("t3_err", 32'(err_cnt), 32'd1);

        // SOF value inside the payload is data.
        do_reset();
        send(8'h7E, 1); send(8'h04, 1); send(8'h01, 1); send(8'h7E, 1); send(8'h02, 1);
        send(8'h03, 1); send(8'h78, 1);
        exp_q.push_back(10'h001); exp_q.push_back(10'h07E); exp_q.push_back(10'h002);
        exp_q.push_back(10'h103);
        expect_out("t4");
        check_eq("t4_ok", 32'(ok_cnt), 32'd1);
        check_eq("t4_err", 32'(err_cnt), 32'd0);

        // Timeout abort, then a good frame and a frame with a gap just under the limit.
        do_reset();
        send(8'h7E, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1);
        idle(TO + 10);
        exp_q.push_back(10'h011); exp_q.push_back(10'h322);
        expect_out("t5");
        check_eq("t5_err", 32'(err_cnt), 32'd1);
        send_frame1();
        expect_frame1();
        expect_out("t5_next");
        send(8'h7E, 1); send(8'h01, 1);
        idle(TO - 5);
        send(8'h5A, 1); send(8'hA5, 1);
        exp_q.push_back(10'h15A);
        expect_out("t5_gap");
        check_eq("t5_ok", 32'(ok_cnt), 32'd2);
        check_eq("t5_err_final", 32'(err_cnt), 32'd1);

        // Downstream stall for 20 cycles mid-frame.
        do_reset();
        saw_valid = 1'b0;
        rdy_low   = 1'b1;
        stable    = 1'b1;
        snap      = '0;
        fork
            send_frame1();
            begin
                for (int i = 0; i < 100 && !saw_valid; i++) begin
                    @(negedge clk);
                    if (m_if.tvalid) saw_valid = 1'b1;
                end
                @(posedge clk);
                #1;
                m_if.tready = 1'b0;
                @(negedge clk);
                snap = {m_if.tvalid, m_if.tlast, m_if.tdata};
                repeat (20) begin
                    @(negedge clk);
                    if (s_if.tready !== 1'b0) rdy_low = 1'b0;
                    if ({m_if.tvalid, m_if.tlast, m_if.tdata} !== snap) stable = 1'b0;
                end
                @(posedge clk);
                #1;
                m_if.tready = 1'b1;
            end
        join
        check_eq("t6_saw_valid", 32'(saw_valid), 32'd1);
        check_eq("t6_held_valid", 32'(snap[9]), 32'd1);
        check_eq("t6_s_tready_low", 32'(rdy_low), 32'd1);
        check_eq("t6_m_stable", 32'(stable), 32'd1);
        expect_frame1();
        expect_out("t6");
        send(8'h7E, 1); send(8'h00, 1); send(8'h00, 1);
        expect_out("t6_len0");
        check_eq("t6_ok", 32'(ok_cnt), 32'd2);

        // Asynchronous reset mid-frame discards pend and output.
        send(8'h7E, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t7_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check_eq("t7_rst_counters", 32'({ok_cnt, err_cnt}), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        got_q.delete();
        send_frame1();
        expect_frame1();
        expect_out("t7");
        check_eq("t7_ok", 32'(ok_cnt), 32'd1);

        // Counter saturation at all-ones.
        do_reset();
        repeat (9) begin
            send(8'h7E, 1); send(8'h00, 1); send(8'h00, 1);
        end
        repeat (9) begin
            send(8'h7E, 1); send(8'h00, 1); send(8'h01, 1);
        end
        expect_out("t8");
        check_eq("t8_ok_sat", 32'(ok_cnt), 32'd7);
        check_eq("t8_err_sat", 32'(err_cnt), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
